// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences launch/halt, selects next PC
// (sequential or relative redirect) and counts RUN cycles for benchmarking.
module fetch_unit #(
  parameter int          PC_W    = 10,
  parameter int          INSTR_W = 9,
  parameter int          OFF_W   = 8,
  parameter int unsigned START0  = 0,
  parameter int unsigned START1  = 256,
  parameter int unsigned START2  = 512,
  parameter int unsigned START3  = 768,
  parameter int          CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         prog_sel,
  input  logic               done_in,
  input  logic               branch,
  input  logic               jump,
  input  logic               cond_met,
  input  logic [OFF_W-1:0]   offset,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
    logic [PC_W-1:0] a;
    case (sel)
      2'd0:    a = PC_W'(START0);
      2'd1:    a = PC_W'(START1);
      2'd2:    a = PC_W'(START2);
      2'd3:    a = PC_W'(START3);
      default: a = PC_W'(START0);
    endcase
    return a;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;

  logic [PC_W-1:0]  off_sext_s;
  logic [PC_W-1:0]  pc_seq_s;
  logic             redirect_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign off_sext_s = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign pc_seq_s   = pc_q + PC_ONE;
  assign redirect_s = jump | (branch & cond_met);
  assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state, next-PC and counter selection; start in RUN outranks done_in and redirects
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        pc_d  = start_addr(prog_sel);
        cnt_d = '0;
        if (start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc_s;
        if (start) begin
          state_d = S_LOAD;
          pc_d    = start_addr(prog_sel);
        end else if (done_in) begin
          state_d = S_HALT;
        end else if (redirect_s) begin
          pc_d = pc_seq_s + off_sext_s;
        end else begin
          pc_d = pc_seq_s;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
    valid_d  = (state_d == S_RUN);
    halted_d = (state_d == S_HALT);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign cycle_count = cnt_q;
  // Memory read is combinational on pc, so instr cannot be re-registered without adding a bubble
  assign instr       = valid_q ? imem_rdata : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: launch, redirects, wrap-around, halt, abort,
// relaunch and mid-run reset, checked against hand-computed PCs and counts.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       done_in;
  logic       branch;
  logic       jump;
  logic       cond_met;
  logic [7:0] offset;
  logic [8:0] imem_rdata;
  logic [9:0] imem_addr;
  logic [9:0] pc;
  logic [8:0] instr;
  logic       instr_valid;
  logic       halted;
  logic [15:0] cycle_count;

  int total_s;
  int bad_s;
  int exp_cnt_s;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel),
    .done_in(done_in), .branch(branch), .jump(jump), .cond_met(cond_met),
    .offset(offset), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .halted(halted),
    .cycle_count(cycle_count)
  );

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [8:0] mem_word(input logic [9:0] a);
    logic [9:0] t;
    t = a * 10'd3 + 10'd1;
    return t[8:0] ^ 9'h0A5;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_s = total_s + 1;
    if (got !== exp) begin
      bad_s = bad_s + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle: advance, check fetch outputs, then bump the expected count
  task automatic run_step(input string tag, input logic [9:0] exp_pc);
    tick();
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_addr"}, 32'(imem_addr), 32'(exp_pc));
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(instr), 32'(mem_word(exp_pc)));
    chk({tag, "_cnt"}, 32'(cycle_count), 32'(exp_cnt_s));
    exp_cnt_s = exp_cnt_s + 1;
  endtask

  task automatic idle_chk(input string tag, input logic [9:0] exp_pc, input logic exp_halt,
                          input logic [15:0] exp_cnt);
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'(exp_halt));
    chk({tag, "_cnt"}, 32'(cycle_count), 32'(exp_cnt));
  endtask

  initial begin
    total_s   = 0;
    bad_s     = 0;
    exp_cnt_s = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    prog_sel  = 2'd0;
    done_in   = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    cond_met  = 1'b0;
    offset    = 8'd0;

    tick();
    tick();
    idle_chk("reset", 10'd0, 1'b0, 16'd0);

    // Launch program 2
    rst_n    = 1'b1;
    start    = 1'b1;
    prog_sel = 2'd2;
    tick();
    idle_chk("load1", 10'd0, 1'b0, 16'd0);
    tick();
    idle_chk("load2", 10'd512, 1'b0, 16'd0);
    tick();
    idle_chk("load3", 10'd512, 1'b0, 16'd0);
    start = 1'b0;
    exp_cnt_s = 0;
    for (int a = 512; a <= 520; a++) run_step("seq", 10'(a));

    // Taken branch back by 5, then not-taken, then jumps forward
    branch = 1'b1; cond_met = 1'b1; offset = 8'hFB;
    run_step("br_taken", 10'd516);
    cond_met = 1'b0;
    run_step("br_not", 10'd517);
    branch = 1'b0; jump = 1'b1; offset = 8'd12;
    run_step("jmp12", 10'd530);
    offset = 8'd10;
    run_step("jmp10", 10'd541);
    jump = 1'b1; branch = 1'b1; cond_met = 1'b0; offset = 8'd2;
    run_step("jmp_br", 10'd544);
    jump = 1'b0; branch = 1'b0;

    // Abort to program 3 and exercise wrap-around in both directions
    start = 1'b1; prog_sel = 2'd3;
    tick();
    idle_chk("abort3", 10'd768, 1'b0, 16'(exp_cnt_s));
    start = 1'b0;
    exp_cnt_s = 0;
    run_step("p3_first", 10'd768);
    jump = 1'b1; offset = 8'd127;
    run_step("p3_j127", 10'd896);
    offset = 8'd126;
    run_step("p3_j126", 10'd1023);
    jump = 1'b0;
    run_step("wrap_up", 10'd0);
    jump = 1'b1; offset = 8'hFE;
    run_step("wrap_down", 10'd1023);
    jump = 1'b0;

    // start and done together: start wins, back to LOAD with program 2
    start = 1'b1; done_in = 1'b1; prog_sel = 2'd2;
    tick();
    idle_chk("abort_done", 10'd512, 1'b0, 16'(exp_cnt_s));
    start = 1'b0; done_in = 1'b0;
    exp_cnt_s = 0;
    for (int a = 512; a <= 520; a++) run_step("h_seq", 10'(a));
    branch = 1'b1; cond_met = 1'b1; offset = 8'hFF;
    run_step("h_rep", 10'd520);
    branch = 1'b0; cond_met = 1'b0;
    for (int a = 521; a <= 600; a++) run_step("h_seq2", 10'(a));

    // Halt at 600 on the 90th RUN cycle; redirect inputs are ignored while halted
    done_in = 1'b1;
    tick();
    idle_chk("halt", 10'd600, 1'b1, 16'd90);
    done_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      branch   = i[0];
      jump     = i[1];
      cond_met = 1'b1;
      done_in  = i[2];
      offset   = 8'(i * 13);
      tick();
      idle_chk("halt_hold", 10'd600, 1'b1, 16'd90);
    end
    branch = 1'b0; jump = 1'b0; cond_met = 1'b0; done_in = 1'b0;

    // Relaunch program 1 from HALT
    start = 1'b1; prog_sel = 2'd1;
    tick();
    idle_chk("rl_load1", 10'd600, 1'b0, 16'd90);
    tick();
    idle_chk("rl_load2", 10'd256, 1'b0, 16'd0);
    start = 1'b0;
    exp_cnt_s = 0;
    run_step("rl_first", 10'd256);
    jump = 1'b1; offset = 8'd127;
    run_step("rl_j1", 10'd384);
    run_step("rl_j2", 10'd512);
    run_step("rl_j3", 10'd640);
    offset = 8'd59;
    run_step("rl_j4", 10'd700);

    // Reset mid-run at pc=700 with a jump pending
    rst_n = 1'b0;
    tick();
    idle_chk("mid_rst", 10'd0, 1'b0, 16'd0);
    rst_n = 1'b1; jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_chk("post_rst_idle", 10'd0, 1'b0, 16'd0);
    end
    start = 1'b1; prog_sel = 2'd0;
    tick();
    tick();
    start = 1'b0;
    exp_cnt_s = 0;
    run_step("resume", 10'd0);
    run_step("resume2", 10'd1);

    $display("test done: total=%0d bad=%0d", total_s, bad_s);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode controller.
- Owns the program counter (PC), sequences program launch from `start` and halt on `done`, and drives the instruction-memory address.
- Presents the fetched 9-bit instruction to the controller.
- Applies the next-PC selection: PC+1, or PC+1+offset for a taken branch or a jump.
- Keeps a run-cycle counter for benchmarking.

Parameters:
- PC_W, 10, PC and instruction-memory address width.
- INSTR_W, 9, instruction width.
- OFF_W, 8, signed branch/jump offset width; two's complement.
- START0, 0, start address of program 0.
- START1, 256, start address of program 1.
- START2, 512, start address of program 2.
- START3, 768, start address of program 3.
- CNT_W, 16, cycle-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level launch request from the testbench/top.
- prog_sel  in  2  program index; sampled while in LOAD.
- done_in  in  1  halt decode from the controller for the current instruction.
- branch  in  1  current instruction is a conditional branch.
- jump  in  1  current instruction is an unconditional jump.
- cond_met  in  1  branch flag, selected by the ALU/branch-select path.
- offset  in  OFF_W  signed PC offset from the branch LUT/immediate.
- imem_rdata  in  INSTR_W  instruction memory read data; combinational read of imem_addr.
- imem_addr  out  PC_W  equals pc.
- pc  out  PC_W  current program counter.
- instr  out  INSTR_W  instruction to the controller; forced to 0 unless instr_valid.
- instr_valid  out  1  high only in RUN.
- halted  out  1  high only in HALT.
- cycle_count  out  CNT_W  RUN cycles of the current or most recent program.

Behaviour:
- Reset (rst_n=0 at a clock edge) is synchronous and overrides everything, including mid-program.
  - state=IDLE, pc=0, cycle_count=0.
  - instr_valid=0, halted=0, instr=0.
- States:
  - IDLE: pc holds.
    - start=1 -> LOAD.
  - LOAD: every cycle, pc <= START[prog_sel]; cycle_count <= 0.
    - start=1 -> stay in LOAD.
    - start=0 -> RUN. The first RUN cycle fetches START[prog_sel] as last sampled.
  - RUN: instr = imem_rdata; cycle_count increments by 1 per cycle, saturating at 2^CNT_W-1.
    - start=1 -> LOAD (abort and relaunch). Takes priority over done_in and redirects; pc still updates to START[prog_sel].
    - else done_in=1 -> HALT. pc holds at the halt instruction address. The halt cycle is counted.
    - else if jump=1 or (branch=1 and cond_met=1): pc <= pc + 1 + sext(offset).
    - else: pc <= pc + 1.
  - HALT: pc and cycle_count hold; halted=1.
    - start=1 -> LOAD. This is the only exit besides reset.
- Next-PC arithmetic:
  - Computed modulo 2^PC_W; wrap-around is silent (1023+1 -> 0; 0+1+(-2) -> 1023).
  - offset is sign-extended to PC_W.
- Input qualification:
  - jump and branch both high: treated as a taken redirect.
  - branch=1, cond_met=0: pc+1.
  - done_in, branch, jump and cond_met are ignored outside RUN.
- Latency: a redirect is visible on pc/imem_addr in the cycle after the branch instruction. No delay slot; no bubble.
- instr is 0 in IDLE, LOAD and HALT. The controller then decodes opcode 000 (addi) with start/done gating its writes. The team accepts this; the controller's start/done inputs still gate writes.

Test Plan:
- Reset/launch: hold rst_n=0 two cycles; start=1, prog_sel=2 three cycles, then start=0.
  - During reset and LOAD: pc=0 and 512 respectively, instr_valid=0.
  - First RUN cycle: pc=512, instr=imem[512]; then 513, 514 on consecutive cycles.
- Branch: at pc=520, branch=1, cond_met=1, offset=-5 -> next pc=516.
  - Repeat with cond_met=0 -> next pc=521.
  - jump=1, offset=+10 at pc=530 -> next pc=541.
- Wrap-around: at pc=1023 with no redirect -> pc=0.
  - At pc=0, jump, offset=-2 -> pc=1023.
- Halt: done_in=1 at pc=600 after 89 RUN cycles.
  - halted=1, pc stays at 600, cycle_count stays at 90 for 20 idle cycles.
  - Branch/jump toggled during HALT cause no pc change.
- Relaunch and abort:
  - From HALT, start=1 with prog_sel=1, then start=0 -> cycle_count=0 in LOAD, pc=256 in the first RUN cycle.
  - In RUN, assert start=1 with done_in=1 simultaneously -> LOAD (not HALT), pc=START[prog_sel].
- Reset mid-run: rst_n=0 for one cycle at pc=700 with jump=1 -> state IDLE, pc=0, cycle_count=0, instr_valid=0.
  - start=1 thereafter is required to resume.
